// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with load-use hazard detection; bubbles on flush or load-use.
// Latency: 1 clock from ID inputs to EX outputs; o_hazard_stall is combinational (0 cycles).
// Backpressure: i_step=0 freezes the latch; o_hazard_stall asks PC/IF-ID to hold for one edge.
module id_ex_latch #(
    parameter int NB_DATA  = 32,
    parameter int NB_REG   = 5,
    parameter int NB_ALUOP = 4
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_step,
    input  logic                i_flush,
    input  logic                i_valid,
    input  logic [NB_DATA-1:0]  i_pc_plus4,
    input  logic [NB_DATA-1:0]  i_rs_data,
    input  logic [NB_DATA-1:0]  i_rt_data,
    input  logic [NB_DATA-1:0]  i_ext_imm,
    input  logic [NB_REG-1:0]   i_rs,
    input  logic [NB_REG-1:0]   i_rt,
    input  logic [NB_REG-1:0]   i_rd,
    input  logic [NB_REG-1:0]   i_shamt,
    input  logic                i_uses_rs,
    input  logic                i_uses_rt,
    input  logic                i_RegWrite,
    input  logic                i_MemRead,
    input  logic                i_MemWrite,
    input  logic                i_MemToReg,
    input  logic                i_ALUSrc,
    input  logic [1:0]          i_RegDst,
    input  logic [NB_ALUOP-1:0] i_ALUOp,
    output logic                o_valid,
    output logic [NB_DATA-1:0]  o_pc_plus4,
    output logic [NB_DATA-1:0]  o_rs_data,
    output logic [NB_DATA-1:0]  o_rt_data,
    output logic [NB_DATA-1:0]  o_ext_imm,
    output logic [NB_REG-1:0]   o_rs,
    output logic [NB_REG-1:0]   o_rt,
    output logic [NB_REG-1:0]   o_rd,
    output logic [NB_REG-1:0]   o_shamt,
    output logic                o_RegWrite,
    output logic                o_MemRead,
    output logic                o_MemWrite,
    output logic                o_MemToReg,
    output logic                o_ALUSrc,
    output logic [1:0]          o_RegDst,
    output logic [NB_ALUOP-1:0] o_ALUOp,
    output logic                o_hazard_stall
);

    // Decoded control word; cleared as a unit for bubbles and non-instructions.
    typedef struct packed {
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                alu_src;
        logic [1:0]          reg_dst;
        logic [NB_ALUOP-1:0] alu_op;
    } ctrl_t;

    // Operands and instruction fields carried to EX.
    typedef struct packed {
        logic [NB_DATA-1:0] pc_plus4;
        logic [NB_DATA-1:0] rs_data;
        logic [NB_DATA-1:0] rt_data;
        logic [NB_DATA-1:0] ext_imm;
        logic [NB_REG-1:0]  rs;
        logic [NB_REG-1:0]  rt;
        logic [NB_REG-1:0]  rd;
        logic [NB_REG-1:0]  shamt;
    } data_t;

    logic  valid_d, valid_q;
    ctrl_t ctrl_d,  ctrl_q;
    data_t data_d,  data_q;
    ctrl_t ctrl_in;
    data_t data_in;
    logic  hazard;

    assign ctrl_in = '{reg_write:  i_RegWrite,
                       mem_read:   i_MemRead,
                       mem_write:  i_MemWrite,
                       mem_to_reg: i_MemToReg,
                       alu_src:    i_ALUSrc,
                       reg_dst:    i_RegDst,
                       alu_op:     i_ALUOp};

    assign data_in = '{pc_plus4: i_pc_plus4,
                       rs_data:  i_rs_data,
                       rt_data:  i_rt_data,
                       ext_imm:  i_ext_imm,
                       rs:       i_rs,
                       rt:       i_rt,
                       rd:       i_rd,
                       shamt:    i_shamt};

    // Load in EX whose destination ($zero excluded) is read by the instruction in ID.
    // Deliberately not gated by i_step so upstream sees the request even while frozen.
    always_comb begin
        hazard = valid_q & ctrl_q.mem_read & i_valid & (data_q.rt != '0) &
                 ((i_uses_rs & (i_rs == data_q.rt)) | (i_uses_rt & (i_rt == data_q.rt)));
    end

    // Next-state: freeze, then bubble (flush or load-use), then normal load.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (!i_step) begin
            valid_d = valid_q;
        end else if (i_flush || hazard) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            data_d  = '0;
        end else begin
            valid_d = i_valid;
            data_d  = data_in;
            // A non-instruction still carries data but must never write state.
            ctrl_d  = i_valid ? ctrl_in : '0;
        end
    end

    // Pipeline register with asynchronous clear.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign o_valid        = valid_q;
    assign o_pc_plus4     = data_q.pc_plus4;
    assign o_rs_data      = data_q.rs_data;
    assign o_rt_data      = data_q.rt_data;
    assign o_ext_imm      = data_q.ext_imm;
    assign o_rs           = data_q.rs;
    assign o_rt           = data_q.rt;
    assign o_rd           = data_q.rd;
    assign o_shamt        = data_q.shamt;
    assign o_RegWrite     = ctrl_q.reg_write;
    assign o_MemRead      = ctrl_q.mem_read;
    assign o_MemWrite     = ctrl_q.mem_write;
    assign o_MemToReg     = ctrl_q.mem_to_reg;
    assign o_ALUSrc       = ctrl_q.alu_src;
    assign o_RegDst       = ctrl_q.reg_dst;
    assign o_ALUOp        = ctrl_q.alu_op;
    assign o_hazard_stall = hazard;

endmodule

// File: tb/tb_id_ex_latch.sv
// Testbench for id_ex_latch: directed table, multi-cycle corner sequences, random vs model.
// Latency: checks outputs 1 ns after each rising edge, hazard 1 ns after inputs change.
// Backpressure: exercises i_step freezes and load-use stalls.
module tb_id_ex_latch;

    typedef struct packed {
        logic        step, flush, valid;
        logic [31:0] pc, rsd, rtd, imm;
        logic [4:0]  rs, rt, rd, shamt;
        logic        urs, urt, rw, mr, mw, m2r, asrc;
        logic [1:0]  rdst;
        logic [3:0]  aop;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rsd, rtd, imm;
        logic [4:0]  rs, rt, rd, shamt;
        logic        rw, mr, mw, m2r, asrc;
        logic [1:0]  rdst;
        logic [3:0]  aop;
    } out_t;

    typedef struct {
        in_t         in;
        logic        hz;
        logic        v, mr, rw;
        logic [31:0] imm;
    } vec_t;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_step, i_flush, i_valid;
    logic [31:0] i_pc_plus4, i_rs_data, i_rt_data, i_ext_imm;
    logic [4:0]  i_rs, i_rt, i_rd, i_shamt;
    logic        i_uses_rs, i_uses_rt;
    logic        i_RegWrite, i_MemRead, i_MemWrite, i_MemToReg, i_ALUSrc;
    logic [1:0]  i_RegDst;
    logic [3:0]  i_ALUOp;
    logic        o_valid;
    logic [31:0] o_pc_plus4, o_rs_data, o_rt_data, o_ext_imm;
    logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
    logic        o_RegWrite, o_MemRead, o_MemWrite, o_MemToReg, o_ALUSrc;
    logic [1:0]  o_RegDst;
    logic [3:0]  o_ALUOp;
    logic        o_hazard_stall;

    int   n_chk  = 0;
    int   n_fail = 0;
    out_t exp_s  = '0;

    id_ex_latch dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_step(i_step), .i_flush(i_flush),
        .i_valid(i_valid), .i_pc_plus4(i_pc_plus4), .i_rs_data(i_rs_data),
        .i_rt_data(i_rt_data), .i_ext_imm(i_ext_imm), .i_rs(i_rs), .i_rt(i_rt),
        .i_rd(i_rd), .i_shamt(i_shamt), .i_uses_rs(i_uses_rs), .i_uses_rt(i_uses_rt),
        .i_RegWrite(i_RegWrite), .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite),
        .i_MemToReg(i_MemToReg), .i_ALUSrc(i_ALUSrc), .i_RegDst(i_RegDst),
        .i_ALUOp(i_ALUOp), .o_valid(o_valid), .o_pc_plus4(o_pc_plus4),
        .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_ext_imm(o_ext_imm),
        .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_shamt(o_shamt),
        .o_RegWrite(o_RegWrite), .o_MemRead(o_MemRead), .o_MemWrite(o_MemWrite),
        .o_MemToReg(o_MemToReg), .o_ALUSrc(o_ALUSrc), .o_RegDst(o_RegDst),
        .o_ALUOp(o_ALUOp), .o_hazard_stall(o_hazard_stall)
    );

    always #5 i_clock = ~i_clock;

    // ---------------- reference model ----------------
    // Load-use: EX is a real load to a nonzero register that ID actually reads.
    function automatic logic model_hz(out_t s, in_t x);
        logic reads;
        reads = (x.urs && x.rs == s.rt) || (x.urt && x.rt == s.rt);
        return s.valid && s.mr && x.valid && (s.rt != 0) && reads;
    endfunction

    function automatic out_t model_next(out_t s, in_t x);
        out_t r;
        if (!x.step) return s;
        if (x.flush || model_hz(s, x)) return '0;
        r = '0;
        r.valid = x.valid;
        r.pc = x.pc; r.rsd = x.rsd; r.rtd = x.rtd; r.imm = x.imm;
        r.rs = x.rs; r.rt = x.rt; r.rd = x.rd; r.shamt = x.shamt;
        if (x.valid) begin
            r.rw = x.rw; r.mr = x.mr; r.mw = x.mw; r.m2r = x.m2r;
            r.asrc = x.asrc; r.rdst = x.rdst; r.aop = x.aop;
        end
        return r;
    endfunction

    // ---------------- helpers ----------------
    function automatic in_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic urs,
                               logic urt, logic mr, logic [31:0] imm);
        in_t x;
        x = '0;
        x.step = 1'b1; x.valid = v;
        x.rs = rs; x.rt = rt; x.rd = rt + 5'd1; x.shamt = 5'd3;
        x.urs = urs; x.urt = urt;
        x.imm = imm; x.pc = imm + 32'd100;
        x.rsd = 32'hA000_0000 | imm; x.rtd = 32'hB000_0000 | imm;
        x.rw = 1'b1; x.mr = mr; x.m2r = mr; x.asrc = mr;
        x.rdst = mr ? 2'b00 : 2'b01;
        x.aop  = mr ? 4'h0 : 4'h2;
        return x;
    endfunction

    function automatic in_t rnd_in();
        in_t x;
        x = '0;
        x.step  = ($urandom_range(0, 7) != 0);
        x.flush = ($urandom_range(0, 9) == 0);
        x.valid = ($urandom_range(0, 5) != 0);
        x.pc = $urandom; x.rsd = $urandom; x.rtd = $urandom; x.imm = $urandom;
        x.rs = 5'($urandom_range(0, 3)); x.rt = 5'($urandom_range(0, 3));
        x.rd = 5'($urandom); x.shamt = 5'($urandom);
        x.urs = 1'($urandom); x.urt = 1'($urandom);
        x.rw = 1'($urandom); x.mr = ($urandom_range(0, 2) == 0); x.mw = 1'($urandom);
        x.m2r = 1'($urandom); x.asrc = 1'($urandom);
        x.rdst = 2'($urandom_range(0, 2)); x.aop = 4'($urandom);
        return x;
    endfunction

    task automatic drive(in_t x);
        i_step = x.step; i_flush = x.flush; i_valid = x.valid;
        i_pc_plus4 = x.pc; i_rs_data = x.rsd; i_rt_data = x.rtd; i_ext_imm = x.imm;
        i_rs = x.rs; i_rt = x.rt; i_rd = x.rd; i_shamt = x.shamt;
        i_uses_rs = x.urs; i_uses_rt = x.urt;
        i_RegWrite = x.rw; i_MemRead = x.mr; i_MemWrite = x.mw;
        i_MemToReg = x.m2r; i_ALUSrc = x.asrc; i_RegDst = x.rdst; i_ALUOp = x.aop;
    endtask

    function automatic out_t sample();
        out_t r;
        r.valid = o_valid;
        r.pc = o_pc_plus4; r.rsd = o_rs_data; r.rtd = o_rt_data; r.imm = o_ext_imm;
        r.rs = o_rs; r.rt = o_rt; r.rd = o_rd; r.shamt = o_shamt;
        r.rw = o_RegWrite; r.mr = o_MemRead; r.mw = o_MemWrite; r.m2r = o_MemToReg;
        r.asrc = o_ALUSrc; r.rdst = o_RegDst; r.aop = o_ALUOp;
        return r;
    endfunction

    task automatic chk(string name, logic [191:0] act, logic [191:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check hazard, clock, check registered outputs.
    task automatic tick(string name, in_t x);
        drive(x);
        #1;
        chk({name, "_hz"}, 192'(o_hazard_stall), 192'(model_hz(exp_s, x)));
        @(posedge i_clock);
        exp_s = model_next(exp_s, x);
        #1;
        chk({name, "_out"}, 192'(sample()), 192'(exp_s));
        @(negedge i_clock);
    endtask

    vec_t tbl[11];
    in_t  x, y;
    out_t snap;

    initial begin
        // ---------- reset with non-zero inputs, no clock edge yet ----------
        x = mk(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 32'h1234_5678);
        drive(x);
        #3;
        chk("reset_out", 192'(sample()), 192'(out_t'('0)));
        chk("reset_hz", 192'(o_hazard_stall), 192'(0));
        @(negedge i_clock);
        @(negedge i_clock);
        i_reset = 1'b1;
        exp_s = '0;

        // ---------- first load after release ----------
        x = mk(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 32'hFFFF_AAAA);
        tick("first_load", x);
        chk("first_imm", 192'(o_ext_imm), 192'(32'hFFFF_AAAA));
        chk("first_aluop", 192'(o_ALUOp), 192'(4'h2));
        chk("first_valid", 192'(o_valid), 192'(1));

        // ---------- directed table ----------
        x = '0; x.step = 1'b1; x.flush = 1'b1;
        tick("pre_flush", x);
        tbl[0]  = '{mk(1, 1, 8, 1, 0, 1, 32'h4),    0, 1, 1, 1, 32'h4};
        tbl[1]  = '{mk(1, 8, 2, 1, 1, 0, 32'h11),   1, 0, 0, 0, 32'h0};
        tbl[2]  = '{mk(1, 8, 2, 1, 1, 0, 32'h11),   0, 1, 0, 1, 32'h11};
        tbl[3]  = '{mk(1, 1, 0, 1, 0, 1, 32'h5),    0, 1, 1, 1, 32'h5};
        tbl[4]  = '{mk(1, 0, 0, 1, 1, 0, 32'h6),    0, 1, 0, 1, 32'h6};
        tbl[5]  = '{mk(1, 1, 8, 1, 0, 1, 32'h7),    0, 1, 1, 1, 32'h7};
        tbl[6]  = '{mk(1, 3, 8, 1, 0, 0, 32'h8),    0, 1, 0, 1, 32'h8};
        tbl[7]  = '{mk(1, 1, 9, 1, 0, 1, 32'h9),    0, 1, 1, 1, 32'h9};
        tbl[8]  = '{mk(1, 2, 9, 0, 1, 0, 32'hA),    1, 0, 0, 0, 32'h0};
        tbl[8].in.flush = 1'b1;
        tbl[9]  = '{mk(0, 1, 7, 0, 0, 1, 32'h77),   0, 0, 0, 0, 32'h77};
        tbl[10] = '{mk(1, 7, 3, 1, 0, 0, 32'h12),   0, 1, 0, 1, 32'h12};
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].in);
            #1;
            chk($sformatf("tbl%0d_hz", i), 192'(o_hazard_stall), 192'(tbl[i].hz));
            @(posedge i_clock);
            exp_s = model_next(exp_s, tbl[i].in);
            #1;
            chk($sformatf("tbl%0d_ctl", i), 192'({o_valid, o_MemRead, o_RegWrite}),
                192'({tbl[i].v, tbl[i].mr, tbl[i].rw}));
            chk($sformatf("tbl%0d_imm", i), 192'(o_ext_imm), 192'(tbl[i].imm));
            chk($sformatf("tbl%0d_all", i), 192'(sample()), 192'(exp_s));
            @(negedge i_clock);
        end

        // ---------- step freeze for 3 edges, then capture ----------
        snap = sample();
        for (int i = 0; i < 3; i++) begin
            x = mk(1, 5'(i + 4), 5'(i + 5), 1, 1, 0, 32'(i + 32'h300));
            x.step = 1'b0;
            tick($sformatf("freeze%0d", i), x);
            chk($sformatf("freeze%0d_snap", i), 192'(sample()), 192'(snap));
        end
        x = mk(1, 5'd4, 5'd5, 1, 1, 0, 32'h0000_0400);
        tick("unfreeze", x);
        chk("unfreeze_imm", 192'(o_ext_imm), 192'(32'h400));

        // ---------- flush while frozen holds; hazard stays asserted until stepped ----------
        tick("lw8", mk(1, 5'd1, 5'd8, 1, 0, 1, 32'h500));
        snap = sample();
        y = mk(1, 5'd8, 5'd2, 1, 0, 0, 32'h501);
        y.step = 1'b0; y.flush = 1'b1;
        tick("flush_frozen", y);
        chk("flush_frozen_snap", 192'(sample()), 192'(snap));
        y.flush = 1'b0;
        tick("hz_frozen", y);
        chk("hz_frozen_level", 192'(o_hazard_stall), 192'(1));
        y.step = 1'b1;
        tick("hz_bubble", y);
        chk("hz_bubble_ctl", 192'({o_valid, o_RegWrite, o_hazard_stall}), 192'(0));
        tick("hz_follow", y);
        chk("hz_follow_imm", 192'(o_ext_imm), 192'(32'h501));

        // ---------- asynchronous reset mid-operation ----------
        tick("lw8b", mk(1, 5'd1, 5'd8, 1, 0, 1, 32'h600));
        drive(mk(1, 5'd8, 5'd3, 1, 0, 0, 32'h601));
        #1;
        chk("midrst_pre_hz", 192'(o_hazard_stall), 192'(1));
        #1;
        i_reset = 1'b0;
        exp_s = '0;
        #0.5;
        chk("midrst_out", 192'(sample()), 192'(out_t'('0)));
        chk("midrst_hz", 192'(o_hazard_stall), 192'(0));
        @(negedge i_clock);
        i_reset = 1'b1;
        tick("post_rst", mk(1, 5'd8, 5'd3, 1, 0, 0, 32'h601));
        chk("post_rst_valid", 192'(o_valid), 192'(1));

        // ---------- randomized run against the model ----------
        for (int i = 0; i < 400; i++) begin
            tick("rnd", rnd_in());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_latch.md
Name: id_ex_latch

Overview:
- ID/EX pipeline register of the MIPS core.
- Captures the 32-bit sign/zero/upper-extended immediate produced in decode, the register-file read data, the register indices and the decoded control word.
- Presents all of them, registered, to the execute stage.
- Contains the load-use hazard detector: it inserts one bubble and asserts a stall request to PC/IF-ID when the instruction in EX is a load whose destination is read by the instruction in ID.

Parameters:
- NB_DATA, 32, width of data words, PC+4 and the extended immediate.
- NB_REG, 5, width of register indices and shamt.
- NB_ALUOP, 4, width of the ALU operation code.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_step  in  1  global pipeline enable from the debug unit; 0 freezes the latch.
- i_flush  in  1  branch/jump flush; loads a bubble.
- i_valid  in  1  ID holds a real instruction.
- i_pc_plus4  in  NB_DATA  PC+4 of the ID instruction.
- i_rs_data, i_rt_data  in  NB_DATA  register-file read data.
- i_ext_imm  in  NB_DATA  extended immediate from the decode-stage extender.
- i_rs, i_rt, i_rd, i_shamt  in  NB_REG  instruction fields.
- i_uses_rs, i_uses_rt  in  1  the ID instruction reads rs / rt.
- i_RegWrite, i_MemRead, i_MemWrite, i_MemToReg, i_ALUSrc  in  1  control bits.
- i_RegDst  in  2  00 = rt, 01 = rd, 10 = r31.
- i_ALUOp  in  NB_ALUOP  ALU operation.
- o_valid  out  1  EX holds a real instruction.
- o_pc_plus4, o_rs_data, o_rt_data, o_ext_imm  out  NB_DATA  registered copies.
- o_rs, o_rt, o_rd, o_shamt  out  NB_REG  registered copies.
- o_RegWrite, o_MemRead, o_MemWrite, o_MemToReg, o_ALUSrc  out  1  registered copies.
- o_RegDst  out  2  registered copy.
- o_ALUOp  out  NB_ALUOP  registered copy.
- o_hazard_stall  out  1  combinational load-use stall request to PC and IF/ID.

Behaviour:
- **Reset:**
  - i_reset = 0 asynchronously clears every registered output to 0, including o_valid = 0.
  - o_hazard_stall therefore evaluates 0 while in reset.
- **Hazard detect (combinational):** o_hazard_stall = o_valid & o_MemRead & i_valid & (o_rt != 0) & ((i_uses_rs & i_rs == o_rt) | (i_uses_rt & i_rt == o_rt)).
  - It is not gated by i_step.
- **Update at each rising edge with i_reset = 1**, first match wins:
  1. i_step = 0: hold all registers unchanged.
  2. i_flush = 1: load a bubble.
  3. o_hazard_stall = 1: load a bubble.
  4. Otherwise: load all inputs, with o_valid <= i_valid.
- **Bubble:** o_valid and every control output (RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, ALUOp) are 0, and all data and index outputs are 0.
- **Latency:** 1 clock from ID inputs to EX outputs.
- **Load-use sequence:**
  - The bubble clears o_MemRead, so o_hazard_stall drops in the next cycle.
  - Exactly one stall cycle per load-use pair.
  - Upstream holds the ID inputs during that cycle, so the dependent instruction is loaded on the following edge.
- **i_valid = 0 on a load edge:** data is loaded, but control outputs are forced to 0 so a non-instruction never writes state.
- **Flush and hazard simultaneously:** flush priority; the result is the same bubble.
- **Hazard while i_step = 0:** the latch holds; o_hazard_stall stays asserted combinationally until a stepped edge consumes it.
- **Register 0:** a load to $zero never causes a stall.
- **Reset mid-operation:** immediate clear regardless of clock. The first edge after release loads normally.

Test Plan:
- **Reset:** hold i_reset = 0 with inputs non-zero, no clock edge -> all outputs 0 and o_hazard_stall = 0. Release, i_step = 1, i_valid = 1, i_ext_imm = 0xFFFFAAAA, i_ALUOp = 4'h2 -> after 1 edge o_ext_imm = 0xFFFFAAAA, o_ALUOp = 2, o_valid = 1.
- **Load-use:** load lw with rt = 8 (MemRead = 1), then ID add with rs = 8, i_uses_rs = 1 -> o_hazard_stall = 1. Next edge gives a bubble (o_valid = 0, o_RegWrite = 0), o_hazard_stall falls to 0, and the following edge loads the add.
- **No hazard cases:**
  - lw with rt = 0 followed by an ID instruction with rs = 0 -> o_hazard_stall stays 0.
  - lw rt = 8 followed by an instruction with i_uses_rt = 0 and rt = 8 -> no stall.
- **Flush priority:** i_flush = 1 together with a valid instruction and an active hazard -> bubble loaded and all control outputs 0. With i_flush = 1 and i_step = 0 -> outputs unchanged.
- **Step freeze:** i_step = 0 for 3 edges while inputs change -> outputs stay identical. i_step = 1 -> the new input is captured on the next edge.
- **Mid-operation reset:** assert i_reset = 0 asynchronously between edges while o_valid = 1 and o_MemRead = 1 -> outputs clear immediately and o_hazard_stall drops in the same time step.
